mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute unit.
- Consumes the execute result (address or ALU value), the auxiliary word (store data or destination register), and the load/store qualifiers.
- Runs a req/ack transaction on the data-memory bus with byte enables, load sign/zero extension, misalignment detection and a bus timeout.
- Drives one registered writeback record per retired instruction, and stalls execute while a transaction is outstanding.

---
 rtl/core_pkg.sv | 18 +
 rtl/mem_align.sv | 52 +++++
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: datapath width, funct3 size codes
// and the bus-transaction state encoding.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Lane steering for data-memory accesses: byte enables, replicated store data,
// sign/zero-extended load data and the alignment/legality check.
module mem_align
  import core_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata     = store_data;
    load_data = rdata;
    illegal   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = (funct3 == F3_B) ? {{(XLEN-8){byte_sel[7]}}, byte_sel}
                                     : {{(XLEN-8){1'b0}}, byte_sel};
      end
      F3_H, F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = (funct3 == F3_H) ? {{(XLEN-16){half_sel[15]}}, half_sel}
                                     : {{(XLEN-16){1'b0}}, half_sel};
        illegal   = addr_lo[0];
      end
      F3_W: begin
        be      = 4'b1111;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants have no store counterpart.
    if (is_store && funct3[2]) illegal = 1'b1;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one req/ack data-bus transaction per
// load/store, times out stuck buses and emits one registered writeback record.
module mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int TCW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_aux,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic            ex_wben,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            flush,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign,
  output logic            bus_err
);
  import core_pkg::*;

  localparam logic [TCW:0] TO_VAL = (TCW+1)'(TIMEOUT);

  state_t          state_reg, state_next;
  logic [TCW-1:0]  cnt_reg, cnt_next;
  logic            req_reg, req_next, we_reg, we_next;
  logic [XLEN-1:0] addr_reg, addr_next, wdata_reg, wdata_next;
  logic [3:0]      be_reg, be_next;
  logic            wb_valid_reg, wb_valid_next;
  logic [4:0]      wb_rd_reg, wb_rd_next, rd_reg, rd_next;
  logic [XLEN-1:0] wb_data_reg, wb_data_next;
  logic            misalign_reg, misalign_next, bus_err_reg, bus_err_next;
  logic [2:0]      f3_reg, f3_next;
  logic [1:0]      alo_reg, alo_next;
  logic            load_reg, load_next, flushed_reg, flushed_next;

  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_load_data;
  logic            al_illegal;
  logic [TCW:0]    cnt_inc;
  logic            timeout_hit;

  // In WAIT the aligner works on the latched op so the ack cycle can extend rdata.
  mem_align u_align (
    .addr_lo    ((state_reg == WAIT) ? alo_reg : ex_result[1:0]),
    .funct3     ((state_reg == WAIT) ? f3_reg : ex_funct3),
    .is_store   (ex_store),
    .store_data (ex_aux),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .illegal    (al_illegal)
  );

  assign cnt_inc     = {1'b0, cnt_reg} + (TCW+1)'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    be_next       = be_reg;
    wdata_next    = wdata_reg;
    wb_valid_next = 1'b0;
    wb_rd_next    = wb_rd_reg;
    wb_data_next  = wb_data_reg;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    rd_next       = rd_reg;
    f3_next       = f3_reg;
    alo_next      = alo_reg;
    load_next     = load_reg;
    flushed_next  = flushed_reg;
    case (state_reg)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_load && !ex_store) begin
            wb_valid_next = ex_wben & ~flush;
            wb_rd_next    = ex_rd;
            wb_data_next  = ex_result;
          end else if (al_illegal) begin
            misalign_next = ~flush;
          end else begin
            state_next   = WAIT;
            cnt_next     = '0;
            req_next     = 1'b1;
            we_next      = ex_store;
            addr_next    = {ex_result[XLEN-1:2], 2'b00};
            be_next      = al_be;
            wdata_next   = al_wdata;
            rd_next      = ex_rd;
            f3_next      = ex_funct3;
            alo_next     = ex_result[1:0];
            load_next    = ex_load;
            flushed_next = flush;
          end
        end
      end
      WAIT: begin
        flushed_next = flushed_reg | flush;
        if (dmem_ack) begin
          state_next   = IDLE;
          req_next     = 1'b0;
          flushed_next = 1'b0;
          if (load_reg && !(flushed_reg || flush)) begin
            wb_valid_next = 1'b1;
            wb_rd_next    = rd_reg;
            wb_data_next  = al_load_data;
          end
        end else if (timeout_hit) begin
          state_next   = IDLE;
          req_next     = 1'b0;
          flushed_next = 1'b0;
          bus_err_next = 1'b1;
        end else begin
          cnt_next = cnt_inc[TCW-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      rd_reg       <= '0;
      f3_reg       <= '0;
      alo_reg      <= '0;
      load_reg     <= 1'b0;
      flushed_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      be_reg       <= be_next;
      wdata_reg    <= wdata_next;
      wb_valid_reg <= wb_valid_next;
      wb_rd_reg    <= wb_rd_next;
      wb_data_reg  <= wb_data_next;
      misalign_reg <= misalign_next;
      bus_err_reg  <= bus_err_next;
      rd_reg       <= rd_next;
      f3_reg       <= f3_next;
      alo_reg      <= alo_next;
      load_reg     <= load_next;
      flushed_reg  <= flushed_next;
    end
  end

  assign stall      = (state_reg == WAIT);
  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;
  assign wb_valid   = wb_valid_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_data    = wb_data_reg;
  assign misalign   = misalign_reg;
  assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus-side checks inline, writebacks checked
// against a scoreboard queue filled when each op is issued.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_wben = 1'b0;
  logic [31:0] ex_result = '0, ex_aux = '0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        flush = 1'b0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_rec_t;

  wb_rec_t exp_q[$];
  int tests = 0;
  int fails = 0;

  mem_stage #(.XLEN(32), .TIMEOUT(4), .TCW(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_aux(ex_aux),
    .ex_load(ex_load), .ex_store(ex_store), .ex_wben(ex_wben),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .flush(flush),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every writeback pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        wb_rec_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        chk("wb_data", wb_data, e.data);
        $display("[TB] wb rd=%0d data=%h", wb_rd, wb_data);
      end
    end
  end

  task automatic issue(input logic ld, input logic st, input logic wben, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] aux, input logic [4:0] rd,
                       input logic fl);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_wben = wben; ex_funct3 = f3;
    ex_result = res; ex_aux = aux; ex_rd = rd; flush = fl;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wben = 1'b0; flush = 1'b0;
    ex_result = $urandom; ex_aux = $urandom;
  endtask

  // Run the WAIT phase: ack arrives in WAIT cycle n, flush in cycle flush_at (0 = none).
  task automatic wait_ack(input int n, input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata,
                          input logic e_wb, input int flush_at);
    int stall_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      if (i == flush_at) flush = 1'b1;
      if (i == n) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      @(negedge clk);
      chk("req_wait", {31'b0, dmem_req}, 32'd1);
      chk("addr", dmem_addr, e_addr);
      chk("be", {28'b0, dmem_be}, {28'b0, e_be});
      chk("we", {31'b0, dmem_we}, {31'b0, e_we});
      if (e_we) chk("wdata", dmem_wdata, e_wdata);
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      dmem_ack = 1'b0; flush = 1'b0; dmem_rdata = $urandom;
    end
    @(negedge clk);
    chk("stall_cycles", stall_cnt, n);
    chk("stall_done", {31'b0, stall}, 32'd0);
    chk("req_done", {31'b0, dmem_req}, 32'd0);
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wb});
    chk("no_bus_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic expect_misalign(input logic st, input logic [2:0] f3, input logic [31:0] a);
    issue(~st, st, 1'b0, f3, a, 32'hDEAD_BEEF, 5'd9, 1'b0);
    @(negedge clk);
    chk("misalign", {31'b0, misalign}, 32'd1);
    chk("misalign_req", {31'b0, dmem_req}, 32'd0);
    chk("misalign_wb", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("misalign_pulse", {31'b0, misalign}, 32'd0);
    @(posedge clk); #1;
    $display("[TB] illegal op f3=%b addr=%h store=%0d", f3, a, st);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_outs", {dmem_we, wb_valid, misalign, bus_err, dmem_be, wb_rd}, 32'd0);
    chk("rst_addr", dmem_addr | dmem_wdata | wb_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU passthrough
    exp_q.push_back('{rd: 5'd5, data: 32'h1234});
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h1234, 32'd5, 5'd5, 1'b0);
    @(negedge clk);
    chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    $display("[TB] alu passthrough rd=5");

    // Non-memory op with wben=0, and one flushed in IDLE: no writeback
    issue(1'b0, 1'b0, 1'b0, 3'b000, 32'h55, 32'd6, 5'd6, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h66, 32'd7, 5'd7, 1'b1);
    @(negedge clk);
    chk("alu_flush_wb", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    $display("[TB] alu no-wben and flushed ops");

    // LB / LBU from 0x103, ack in third WAIT cycle
    exp_q.push_back('{rd: 5'd7, data: 32'hFFFF_FF80});
    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'd7, 5'd7, 1'b0);
    wait_ack(3, 32'h80FF_FF7F, 32'h100, 4'b1000, 1'b0, 32'h0, 1'b1, 0);
    $display("[TB] LB 0x103");
    exp_q.push_back('{rd: 5'd8, data: 32'h0000_0080});
    issue(1'b1, 1'b0, 1'b0, 3'b100, 32'h103, 32'd8, 5'd8, 1'b0);
    wait_ack(3, 32'h80FF_FF7F, 32'h100, 4'b1000, 1'b0, 32'h0, 1'b1, 0);
    $display("[TB] LBU 0x103");

    // LH sign extension from upper half, LHU from lower half
    exp_q.push_back('{rd: 5'd10, data: 32'hFFFF_9ABC});
    issue(1'b1, 1'b0, 1'b0, 3'b001, 32'h602, 32'd10, 5'd10, 1'b0);
    wait_ack(2, 32'h9ABC_1234, 32'h600, 4'b1100, 1'b0, 32'h0, 1'b1, 0);
    exp_q.push_back('{rd: 5'd11, data: 32'h0000_F234});
    issue(1'b1, 1'b0, 1'b0, 3'b101, 32'h600, 32'd11, 5'd11, 1'b0);
    wait_ack(1, 32'h9ABC_F234, 32'h600, 4'b0011, 1'b0, 32'h0, 1'b1, 0);
    $display("[TB] LH/LHU lanes");

    // SH to 0x202 with immediate ack, SB to lane 1
    issue(1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd0, 1'b0);
    wait_ack(1, 32'h0, 32'h200, 4'b1100, 1'b1, 32'hBEEF_BEEF, 1'b0, 0);
    $display("[TB] SH 0x202");
    issue(1'b0, 1'b1, 1'b0, 3'b000, 32'h701, 32'h1234_56A5, 5'd0, 1'b0);
    wait_ack(2, 32'h0, 32'h700, 4'b0010, 1'b1, 32'hA5A5_A5A5, 1'b0, 0);
    $display("[TB] SB 0x701");

    // Illegal ops
    expect_misalign(1'b1, 3'b010, 32'h301);
    expect_misalign(1'b0, 3'b001, 32'h3);
    expect_misalign(1'b0, 3'b011, 32'h0);
    expect_misalign(1'b1, 3'b100, 32'h0);

    // Timeout with no ack
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h400, 32'd12, 5'd12, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("to_req", {31'b0, dmem_req}, 32'd1);
      chk("to_no_err", {31'b0, bus_err}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("to_stall", {31'b0, stall}, 32'd0);
    chk("to_wb", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_pulse", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;
    $display("[TB] LW timeout");

    // Ack coinciding with the timeout cycle wins
    exp_q.push_back('{rd: 5'd13, data: 32'hCAFE_F00D});
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h404, 32'd13, 5'd13, 1'b0);
    wait_ack(4, 32'hCAFE_F00D, 32'h404, 4'b1111, 1'b0, 32'h0, 1'b1, 0);
    $display("[TB] LW ack on timeout cycle");

    // Flush mid-WAIT, flush in ack cycle, flush at accept
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h800, 32'd14, 5'd14, 1'b0);
    wait_ack(3, 32'h1111_2222, 32'h800, 4'b1111, 1'b0, 32'h0, 1'b0, 1);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h804, 32'd15, 5'd15, 1'b0);
    wait_ack(2, 32'h3333_4444, 32'h804, 4'b1111, 1'b0, 32'h0, 1'b0, 2);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h808, 32'd16, 5'd16, 1'b1);
    wait_ack(1, 32'h5555_6666, 32'h808, 4'b1111, 1'b0, 32'h0, 1'b0, 0);
    $display("[TB] flushed loads");

    // Ack while IDLE is ignored
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("idle_ack_wb", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    $display("[TB] stray ack in IDLE");

    // Reset mid-WAIT
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h900, 32'd17, 5'd17, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_req", {31'b0, dmem_req}, 32'd0);
    chk("rstw_stall", {31'b0, stall}, 32'd0);
    chk("rstw_outs", {dmem_we, wb_valid, misalign, bus_err, dmem_be, wb_rd}, 32'd0);
    chk("rstw_data", dmem_addr | dmem_wdata | wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset during WAIT");

    exp_q.push_back('{rd: 5'd3, data: 32'hABCD});
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'hABCD, 32'd3, 5'd3, 1'b0);
    @(negedge clk);
    chk("post_rst_wb", {31'b0, wb_valid}, 32'd1);
    @(posedge clk); #1;
    $display("[TB] alu after reset");

    repeat (2) @(posedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
